dma_resp: RTL and testbench

DMA_RESP -- requirements
Module: dma_resp

---
 rtl/dma_resp_if.sv | 40 ++++
 rtl/dma_resp.sv | 213 +++++++++++++++++++++
 tb/tb_dma_resp.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_resp_if.sv
// CPU register-write port and memory request/response bus of the dma_resp copy engine.
interface dma_resp_if;
    logic        valid_cpu2dma_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_dma2cpu_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport slave (
        input  valid_cpu2dma_i,
        input  addr_i,
        input  wdata_i,
        output ready_dma2cpu_o,
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport master (
        output valid_cpu2dma_i,
        output addr_i,
        output wdata_i,
        input  ready_dma2cpu_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/dma_resp.sv
// Word-by-word memory copy engine (read SRC, write DST, LEN words) programmed by CPU register writes.
// Optional sticky completion interrupt with IRQ_CLR is built only when macro DMA_IRQ_EN is defined.
module dma_resp (
    input  logic      clk_i,
    input  logic      rst_ni,
    dma_resp_if.slave bus,
    output logic      busy_o,
    output logic      done_o,
    output logic      irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] buf_q, buf_d;

    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept_s;
    logic        ack_s;
    logic        irq_clr_s;
    logic [31:0] word_offset_s;
    logic        unused_s;

    // ready_q is high exactly in IDLE, so it doubles as the accept qualifier.
    assign accept_s      = bus.valid_cpu2dma_i & ready_q;
    assign ack_s         = bus.mem_ack_i & mem_req_q;
    assign word_offset_s = {14'd0, idx_d, 2'b00};

    // Next-state, register file and beat bookkeeping.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        irq_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (bus.addr_i[3:2])
                        REG_SRC: src_d = bus.wdata_i;
                        REG_DST: dst_d = bus.wdata_i;
                        REG_LEN: len_d = bus.wdata_i[15:0];
                        REG_CTRL: begin
                            irq_clr_s = bus.wdata_i[1];
                            if (bus.wdata_i[0]) begin
                                idx_d = 16'd0;
                                if (len_q != 16'd0) begin
                                    state_d = ST_RD;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (ack_s) begin
                    buf_d   = bus.mem_rdata_i;
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (ack_s) begin
                    idx_d = idx_q + 16'd1;
                    if ((idx_q + 16'd1) == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every port comes straight from a flop.
    always_comb begin
        ready_d     = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_RD: begin
                mem_req_d  = 1'b1;
                mem_addr_d = src_d + word_offset_s;
            end
            ST_WR: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = dst_d + word_offset_s;
                mem_wdata_d = buf_d;
            end
            ST_DONE: done_d = 1'b1;
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, register file and output flops; reset abandons any beat immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            buf_q       <= 32'd0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.ready_dma2cpu_o = ready_q;
    assign bus.mem_req_o       = mem_req_q;
    assign bus.mem_we_o        = mem_we_q;
    assign bus.mem_addr_o      = mem_addr_q;
    assign bus.mem_wdata_o     = mem_wdata_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;

`ifdef DMA_IRQ_EN
    logic irq_q, irq_d;

    // Completion set wins over a clear landing in the same cycle.
    always_comb begin
        if (state_d == ST_DONE) begin
            irq_d = 1'b1;
        end else if (irq_clr_s) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Sticky interrupt flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o    = irq_q;
    assign unused_s = ^{bus.addr_i[31:4], bus.addr_i[1:0]};
`else
    assign irq_o    = 1'b0;
    assign unused_s = ^{bus.addr_i[31:4], bus.addr_i[1:0], irq_clr_s};
`endif

endmodule

// File: tb/tb_dma_resp.sv
// Randomized self-checking bench for dma_resp: memory responder with configurable ack latency,
// copy-semantics reference model (shadow memory + expected access trace) and reset/stall scenarios.
module tb_dma_resp;

`ifdef DMA_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, done, irq;

    always #5 clk = ~clk;

    dma_resp_if bus ();

    dma_resp dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .busy_o (busy),
        .done_o (done),
        .irq_o  (irq)
    );

    int n_checks = 0;
    int n_err    = 0;

    acc_t        obs_q[$];
    acc_t        exp_q[$];
    logic [31:0] mem    [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];

    int   ack_delay = 0;
    int   wait_cnt  = 0;
    bit   held      = 1'b0;
    acc_t held_v;
    int   busy_cnt  = 0;
    int   done_cnt  = 0;
    int   busy_base, done_base, obs_base;

    logic [31:0] m_src, m_dst;
    logic [15:0] m_len;
    logic        m_irq;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    // Memory responder and bus monitor: acks each beat after ack_delay waiting cycles.
    always @(negedge clk) begin
        acc_t        cur;
        logic [31:0] d;
        if (!rst_n) begin
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = 32'd0;
            wait_cnt        = 0;
            held            = 1'b0;
        end else begin
            check("ready_iff_idle", 65'(bus.ready_dma2cpu_o), 65'(!busy));
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (bus.mem_req_o) begin
                cur = {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o};
                if (held) check("beat_stable", 65'(cur), 65'(held_v));
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_we_o) begin
                        mem[bus.mem_addr_o] = bus.mem_wdata_o;
                        obs_q.push_back(cur);
                    end else begin
                        d = memrd(bus.mem_addr_o);
                        bus.mem_rdata_i = d;
                        obs_q.push_back({1'b0, bus.mem_addr_o, d});
                    end
                    wait_cnt = 0;
                    held     = 1'b0;
                end else begin
                    bus.mem_ack_i   = 1'b0;
                    bus.mem_rdata_i = $urandom;
                    wait_cnt++;
                    held   = 1'b1;
                    held_v = cur;
                end
            end else begin
                check("idle_bus_zero", 65'({bus.mem_addr_o, bus.mem_wdata_o}), 65'd0);
                bus.mem_ack_i   = 1'($urandom_range(0, 1));
                bus.mem_rdata_i = $urandom;
                wait_cnt        = 0;
                held            = 1'b0;
            end
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.addr_i          = a;
        bus.wdata_i         = d;
        bus.valid_cpu2dma_i = 1'b1;
        while (!bus.ready_dma2cpu_o && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("cpu_accept_in_time", 65'(n < 4000), 65'd1);
        @(posedge clk);
        #1;
        bus.valid_cpu2dma_i = 1'b0;
        case (a[3:2])
            2'd0:    m_src = d;
            2'd1:    m_dst = d;
            2'd2:    m_len = d[15:0];
            default: if (d[1] && IRQ_EN) m_irq = 1'b0;
        endcase
    endtask

    // Build the expected trace from the copy rules, then write CTRL with START.
    task automatic kick(input bit clr);
        logic [31:0] a, d;
        exp_q.delete();
        shadow = mem;
        for (int i = 0; i < int'(m_len); i++) begin
            a = m_src + 32'(4 * i);
            d = shadow.exists(a) ? shadow[a] : dflt(a);
            exp_q.push_back({1'b0, a, d});
            a = m_dst + 32'(4 * i);
            shadow[a] = d;
            exp_q.push_back({1'b1, a, d});
        end
        obs_base  = obs_q.size();
        busy_base = busy_cnt;
        done_base = done_cnt;
        cpu_write(32'hC, {30'd0, clr, 1'b1});
        @(negedge clk);
        if (m_len == 16'd0) begin
            check("len0_done_next", 65'(done), 65'd1);
            check("len0_no_req", 65'(bus.mem_req_o), 65'd0);
        end else begin
            check("first_req", 65'({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o}), 65'({2'b10, m_src}));
        end
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                              input bit clr);
        cpu_write(32'h0, s);
        cpu_write(32'h4, d);
        cpu_write(32'h8, {16'd0, len});
        kick(clr);
    endtask

    task automatic finish_xfer(input string tag);
        int n = 0;
        int exp_busy;
        @(negedge clk);
        while ((busy || !bus.ready_dma2cpu_o) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 65'(n < 4000), 65'd1);
        exp_busy = (m_len == 16'd0) ? 1 : 2 * int'(m_len) * (ack_delay + 1) + 1;
        check({tag, "_busy_cycles"}, 65'(busy_cnt - busy_base), 65'(exp_busy));
        check({tag, "_done_pulses"}, 65'(done_cnt - done_base), 65'd1);
        check({tag, "_n_access"}, 65'(obs_q.size() - obs_base), 65'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_base + i < obs_q.size()) check({tag, "_access"}, 65'(obs_q[obs_base + i]), 65'(exp_q[i]));
            if (exp_q[i].we) check({tag, "_dst_data"}, 65'(memrd(exp_q[i].addr)), 65'(shadow[exp_q[i].addr]));
        end
        if (IRQ_EN) m_irq = 1'b1;
        check({tag, "_irq"}, 65'(irq), 65'(m_irq));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   obs_at_rst;
        rst_n               = 1'b0;
        bus.valid_cpu2dma_i = 1'b0;
        bus.addr_i          = 32'd0;
        bus.wdata_i         = 32'd0;
        m_src = 32'd0;
        m_dst = 32'd0;
        m_len = 16'd0;
        m_irq = 1'b0;
        #12;
        check("reset_ctrl", 65'({bus.mem_req_o, busy, done, irq, bus.ready_dma2cpu_o}), 65'(5'b00001));
        check("reset_bus", 65'({bus.mem_addr_o, bus.mem_wdata_o}), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 3-word copy, ack every cycle.
        ack_delay = 0;
        start_xfer(32'h100, 32'h200, 16'd3, 1'b0);
        finish_xfer("basic3");

        // IRQ_CLR alone, then clear+start with LEN=0.
        cpu_write(32'hC, 32'h2);
        @(negedge clk);
        check("irq_cleared", 65'(irq), 65'(m_irq));
        start_xfer(32'h100, 32'h200, 16'd0, 1'b1);
        finish_xfer("len0_clr_start");

        // Slow memory: three waiting cycles per beat.
        ack_delay = 3;
        start_xfer(32'h1000, 32'h2000, 16'd2, 1'b0);
        finish_xfer("slow2");

        // Source address wraps past the top of the address space.
        ack_delay = 1;
        start_xfer(32'hFFFF_FFFC, 32'h0000_8000, 16'd2, 1'b0);
        finish_xfer("wrap");

        // DST write while busy stalls until IDLE; the running copy keeps the old DST.
        ack_delay = 2;
        start_xfer(32'h5000, 32'h6000, 16'd2, 1'b0);
        cpu_write(32'h4, 32'h7000);
        check("dst_write_after_done", 65'(done_cnt - done_base), 65'd1);
        finish_xfer("dst_stall");
        kick(1'b0);
        finish_xfer("new_dst");

        for (int t = 0; t < 8; t++) begin
            ack_delay = $urandom_range(0, 3);
            start_xfer($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                       16'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
            finish_xfer("rand");
        end

        // Reset while a write beat is pending.
        ack_delay = 40;
        start_xfer(32'h3000, 32'h4000, 16'd2, 1'b0);
        n = 0;
        while (!(bus.mem_req_o && bus.mem_we_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_wr", 65'(n < 200), 65'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_now_ctrl", 65'({bus.mem_req_o, busy, done, irq, bus.ready_dma2cpu_o}), 65'(5'b00001));
        check("rst_now_bus", 65'({bus.mem_addr_o, bus.mem_wdata_o}), 65'd0);
        obs_at_rst = obs_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_src = 32'd0;
        m_dst = 32'd0;
        m_len = 16'd0;
        m_irq = 1'b0;
        repeat (20) @(negedge clk);
        check("no_write_after_rst", 65'(obs_q.size()), 65'(obs_at_rst));
        ack_delay = 0;
        kick(1'b0);
        finish_xfer("post_rst_len0");
        cpu_write(32'h8, 32'd1);
        kick(1'b0);
        finish_xfer("post_rst_zero_regs");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
